// File: rtl/uart_rx_async.sv
// UART receiver: 2-flop synchronized rx, 16x oversampled majority vote, 7/8 data bits,
// optional parity, delivered to a holding register or as an active-low FIFO write strobe.
module uart_rx_async #(
  parameter int RX_FIFO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  input  logic       fifo_full,
  output logic [7:0] rx_byte,
  output logic       rx_rdy,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       fifo_write_rx
);

  localparam bit fifo_mode = (RX_FIFO != 0);

  typedef enum logic [2:0] {
    rx_idle,
    rx_start,
    rx_data,
    rx_parity,
    rx_stop
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic        rx_prev_q, rx_prev_d;
  logic [3:0]  samp_cnt_q, samp_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        par_err_q, par_err_d;
  logic        s6_q, s6_d;
  logic        s7_q, s7_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_rdy_q, rx_rdy_d;
  logic        parity_err_q, parity_err_d;
  logic        framing_err_q, framing_err_d;
  logic        overflow_q, overflow_d;
  logic        fifo_write_rx_q, fifo_write_rx_d;

  logic        vote;
  logic        mid;
  logic        wrap;
  logic        last_bit;
  logic [7:0]  new_byte;
  logic        deliver;

  assign vote     = (s6_q & s7_q) | (s6_q & rx_s_q) | (s7_q & rx_s_q);
  assign mid      = (samp_cnt_q == 4'd8);
  assign wrap     = (samp_cnt_q == 4'd15);
  assign last_bit = (bit_cnt_q == (bit8 ? 3'd7 : 3'd6));
  // Bits shift in at the top, so a 7-bit character sits in shift_q[7:1].
  assign new_byte = bit8 ? shift_q : {1'b0, shift_q[7:1]};

  always_comb begin
    // NOTE: every variable gets its default first so no path leaves it unassigned (no latches).
    state_d         = state_q;
    rx_prev_d       = rx_prev_q;
    samp_cnt_d      = samp_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    par_d           = par_q;
    par_err_d       = par_err_q;
    s6_d            = s6_q;
    s7_d            = s7_q;
    rx_byte_d       = rx_byte_q;
    rx_rdy_d        = rx_rdy_q;
    parity_err_d    = parity_err_q;
    framing_err_d   = framing_err_q;
    overflow_d      = overflow_q;
    fifo_write_rx_d = 1'b1;
    deliver         = 1'b0;

    if (baud_clock) begin
      rx_prev_d = rx_s_q;
      if (state_q != rx_idle) samp_cnt_d = samp_cnt_q + 4'd1;
      if (samp_cnt_q == 4'd6) s6_d = rx_s_q;
      if (samp_cnt_q == 4'd7) s7_d = rx_s_q;

      unique case (state_q)
        rx_idle: begin
          // Edge between ticks only: a line held low never restarts reception.
          if (rx_prev_q && !rx_s_q) begin
            state_d    = rx_start;
            samp_cnt_d = 4'd0;
            bit_cnt_d  = 3'd0;
            shift_d    = 8'h00;
            par_d      = 1'b0;
            par_err_d  = 1'b0;
          end
        end
        rx_start: begin
          if (mid && vote)  state_d = rx_idle;
          else if (wrap)    state_d = rx_data;
        end
        rx_data: begin
          if (mid) begin
            shift_d = {vote, shift_q[7:1]};
            par_d   = par_q ^ vote;
          end
          if (wrap) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) state_d = parity_en ? rx_parity : rx_stop;
          end
        end
        rx_parity: begin
          if (mid)  par_err_d = (vote != (odd_n_even ^ par_q));
          if (wrap) state_d = rx_stop;
        end
        rx_stop: begin
          if (mid) begin
            deliver = 1'b1;
            state_d = rx_idle;
          end
        end
        default: state_d = rx_idle;
      endcase
    end

    if (read_rx_byte) begin
      rx_rdy_d   = 1'b0;
      overflow_d = 1'b0;
    end

    if (deliver) begin
      if (fifo_mode ? !fifo_full : (!rx_rdy_q || read_rx_byte)) begin
        rx_byte_d     = new_byte;
        parity_err_d  = par_err_q;
        framing_err_d = !vote;
        if (fifo_mode) fifo_write_rx_d = 1'b0;
        else           rx_rdy_d        = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (fifo_mode) rx_rdy_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      rx_prev_q       <= 1'b1;
      state_q         <= rx_idle;
      samp_cnt_q      <= 4'd0;
      bit_cnt_q       <= 3'd0;
      shift_q         <= 8'h00;
      par_q           <= 1'b0;
      par_err_q       <= 1'b0;
      s6_q            <= 1'b1;
      s7_q            <= 1'b1;
      rx_byte_q       <= 8'h00;
      rx_rdy_q        <= 1'b0;
      parity_err_q    <= 1'b0;
      framing_err_q   <= 1'b0;
      overflow_q      <= 1'b0;
      fifo_write_rx_q <= 1'b1;
    end else begin
      rx_meta_q       <= rx;
      rx_s_q          <= rx_meta_q;
      rx_prev_q       <= rx_prev_d;
      state_q         <= state_d;
      samp_cnt_q      <= samp_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      par_q           <= par_d;
      par_err_q       <= par_err_d;
      s6_q            <= s6_d;
      s7_q            <= s7_d;
      rx_byte_q       <= rx_byte_d;
      rx_rdy_q        <= rx_rdy_d;
      parity_err_q    <= parity_err_d;
      framing_err_q   <= framing_err_d;
      overflow_q      <= overflow_d;
      fifo_write_rx_q <= fifo_write_rx_d;
    end
  end

  assign rx_byte       = rx_byte_q;
  assign rx_rdy        = rx_rdy_q;
  assign parity_err    = parity_err_q;
  assign framing_err   = framing_err_q;
  assign overflow      = overflow_q;
  assign fifo_write_rx = fifo_write_rx_q;

endmodule

// File: tb/tb_uart_rx_async.sv
// Directed bench for uart_rx_async: one holding-register instance and one FIFO-mode
// instance share the serial line; each scenario task checks its own expected values.
module tb_uart_rx_async;

  localparam int TICK_CLKS = 4;
  localparam int BIT_CLKS  = 16 * TICK_CLKS;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_clock = 1'b0;
  logic       rx;
  logic       bit8;
  logic       parity_en;
  logic       odd_n_even;
  logic       read_rx_byte;
  logic       fifo_full;

  logic [7:0] h_rx_byte, f_rx_byte;
  logic       h_rx_rdy, f_rx_rdy;
  logic       h_parity_err, f_parity_err;
  logic       h_framing_err, f_framing_err;
  logic       h_overflow, f_overflow;
  logic       h_fifo_write_rx, f_fifo_write_rx;

  int checks = 0;
  int errors = 0;
  int baud_div = 0;

  int         strobes = 0;
  int         low_cycles = 0;
  logic [7:0] strobe_byte = 8'h00;
  logic       prev_wr = 1'b1;

  uart_rx_async #(.RX_FIFO(0)) dut_hold (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(read_rx_byte),
    .fifo_full(fifo_full), .rx_byte(h_rx_byte), .rx_rdy(h_rx_rdy),
    .parity_err(h_parity_err), .framing_err(h_framing_err), .overflow(h_overflow),
    .fifo_write_rx(h_fifo_write_rx)
  );

  uart_rx_async #(.RX_FIFO(1)) dut_fifo (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(read_rx_byte),
    .fifo_full(fifo_full), .rx_byte(f_rx_byte), .rx_rdy(f_rx_rdy),
    .parity_err(f_parity_err), .framing_err(f_framing_err), .overflow(f_overflow),
    .fifo_write_rx(f_fifo_write_rx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    baud_div   = (baud_div + 1) % TICK_CLKS;
    baud_clock = (baud_div == 0);
  end

  always @(negedge clk) begin
    if (f_fifo_write_rx === 1'b0) begin
      low_cycles = low_cycles + 1;
      if (prev_wr === 1'b1) begin
        strobes     = strobes + 1;
        strobe_byte = f_rx_byte;
      end
    end
    prev_wr = f_fifo_write_rx;
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input bit with_par,
                            input bit par_bit, input bit stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(data[i]);
    if (with_par) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * BIT_CLKS) @(negedge clk);
  endtask

  task automatic pulse_read();
    read_rx_byte = 1'b1;
    @(negedge clk);
    read_rx_byte = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (h_rx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", h_rx_byte); end
    checks++; if (h_rx_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", h_rx_rdy); end
    checks++; if ({h_parity_err, h_framing_err, h_overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {h_parity_err, h_framing_err, h_overflow}); end
    checks++; if ({h_fifo_write_rx, f_fifo_write_rx} !== 2'b11) begin errors++; $display("FAIL reset_wr: got %b expected 11", {h_fifo_write_rx, f_fifo_write_rx}); end
    checks++; if (f_rx_rdy !== 1'b0) begin errors++; $display("FAIL reset_fifo_rdy: got %b expected 0", f_rx_rdy); end
    idle(2);
  endtask

  task automatic test_8n1();
    int s0;
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    s0 = strobes;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    idle(1);
    checks++; if (h_rx_byte !== 8'hA5) begin errors++; $display("FAIL 8n1_byte: got %h expected a5", h_rx_byte); end
    checks++; if (h_rx_rdy !== 1'b1) begin errors++; $display("FAIL 8n1_rdy: got %b expected 1", h_rx_rdy); end
    checks++; if ({h_parity_err, h_framing_err, h_overflow} !== 3'b000) begin errors++; $display("FAIL 8n1_flags: got %b expected 000", {h_parity_err, h_framing_err, h_overflow}); end
    checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL 8n1_strobe: got %0d expected 1", strobes - s0); end
    pulse_read();
    checks++; if (h_rx_rdy !== 1'b0) begin errors++; $display("FAIL 8n1_read_rdy: got %b expected 0", h_rx_rdy); end
  endtask

  task automatic test_parity7();
    bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
    send_frame(8'h53, 7, 1'b1, 1'b0, 1'b1);
    idle(1);
    checks++; if (h_rx_byte !== 8'h53) begin errors++; $display("FAIL 7e1_byte: got %h expected 53", h_rx_byte); end
    checks++; if (h_parity_err !== 1'b0) begin errors++; $display("FAIL 7e1_perr: got %b expected 0", h_parity_err); end
    pulse_read();
    send_frame(8'h53, 7, 1'b1, 1'b1, 1'b1);
    idle(1);
    checks++; if (h_parity_err !== 1'b1) begin errors++; $display("FAIL 7e1_bad_perr: got %b expected 1", h_parity_err); end
    checks++; if (h_rx_rdy !== 1'b1) begin errors++; $display("FAIL 7e1_bad_rdy: got %b expected 1", h_rx_rdy); end
    pulse_read();
    odd_n_even = 1'b1;
    send_frame(8'h00, 7, 1'b1, 1'b1, 1'b1);
    idle(1);
    checks++; if ({h_rx_byte, h_parity_err} !== {8'h00, 1'b0}) begin errors++; $display("FAIL 7o1: got %h/%b expected 00/0", h_rx_byte, h_parity_err); end
    pulse_read();
  endtask

  task automatic test_framing_break();
    int s0;
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    checks++; if ({h_rx_byte, h_framing_err} !== {8'h3C, 1'b1}) begin errors++; $display("FAIL frame_err: got %h/%b expected 3c/1", h_rx_byte, h_framing_err); end
    pulse_read();
    s0 = strobes;
    rx = 1'b0;
    repeat (40 * BIT_CLKS) @(negedge clk);
    checks++; if (strobes - s0 !== 0) begin errors++; $display("FAIL break_strobes: got %0d expected 0", strobes - s0); end
    checks++; if ({h_rx_rdy, h_overflow} !== 2'b00) begin errors++; $display("FAIL break_rdy_ovf: got %b expected 00", {h_rx_rdy, h_overflow}); end
    idle(2);
    send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1);
    idle(1);
    checks++; if ({h_rx_byte, h_framing_err, h_rx_rdy} !== {8'h01, 1'b0, 1'b1}) begin errors++; $display("FAIL after_break: got %h/%b/%b expected 01/0/1", h_rx_byte, h_framing_err, h_rx_rdy); end
    pulse_read();
  endtask

  task automatic test_glitch_overflow();
    int s0;
    s0 = strobes;
    rx = 1'b0;
    repeat (4 * TICK_CLKS) @(negedge clk);
    idle(2);
    checks++; if (strobes - s0 !== 0) begin errors++; $display("FAIL glitch_strobes: got %0d expected 0", strobes - s0); end
    checks++; if (h_rx_rdy !== 1'b0) begin errors++; $display("FAIL glitch_rdy: got %b expected 0", h_rx_rdy); end
    s0 = strobes;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    idle(1);
    checks++; if ({h_rx_byte, h_rx_rdy, h_overflow} !== {8'h11, 1'b1, 1'b1}) begin errors++; $display("FAIL overflow: got %h/%b/%b expected 11/1/1", h_rx_byte, h_rx_rdy, h_overflow); end
    checks++; if ({strobes - s0, strobe_byte} !== {32'd2, 8'h22}) begin errors++; $display("FAIL b2b_fifo: got %0d/%h expected 2/22", strobes - s0, strobe_byte); end
    pulse_read();
    checks++; if ({h_rx_rdy, h_overflow} !== 2'b00) begin errors++; $display("FAIL ovf_read: got %b expected 00", {h_rx_rdy, h_overflow}); end
  endtask

  task automatic test_fifo();
    int s0, l0;
    fifo_full = 1'b0;
    s0 = strobes; l0 = low_cycles;
    send_frame(8'h80, 8, 1'b0, 1'b0, 1'b1);
    idle(1);
    checks++; if ({strobes - s0, low_cycles - l0} !== {32'd1, 32'd1}) begin errors++; $display("FAIL fifo_strobe: got %0d strobes %0d low expected 1/1", strobes - s0, low_cycles - l0); end
    checks++; if (strobe_byte !== 8'h80) begin errors++; $display("FAIL fifo_byte: got %h expected 80", strobe_byte); end
    checks++; if ({f_rx_rdy, f_overflow} !== 2'b00) begin errors++; $display("FAIL fifo_rdy_ovf: got %b expected 00", {f_rx_rdy, f_overflow}); end
    fifo_full = 1'b1;
    s0 = strobes;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    idle(1);
    checks++; if (strobes - s0 !== 0) begin errors++; $display("FAIL fifo_full_strobe: got %0d expected 0", strobes - s0); end
    checks++; if ({f_overflow, f_rx_byte} !== {1'b1, 8'h80}) begin errors++; $display("FAIL fifo_full_ovf: got %b/%h expected 1/80", f_overflow, f_rx_byte); end
    fifo_full = 1'b0;
  endtask

  task automatic test_reset_mid();
    int s0;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({h_rx_byte, h_rx_rdy, h_overflow, h_framing_err, h_parity_err} !== 12'h000) begin errors++; $display("FAIL midreset_hold: got %h/%b/%b/%b/%b expected 00/0/0/0/0", h_rx_byte, h_rx_rdy, h_overflow, h_framing_err, h_parity_err); end
    checks++; if ({f_overflow, f_fifo_write_rx, f_rx_byte} !== {1'b0, 1'b1, 8'h00}) begin errors++; $display("FAIL midreset_fifo: got %b/%b/%h expected 0/1/00", f_overflow, f_fifo_write_rx, f_rx_byte); end
    idle(2);
    s0 = strobes;
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1);
    idle(1);
    checks++; if ({h_rx_byte, h_rx_rdy, h_framing_err} !== {8'h7E, 1'b1, 1'b0}) begin errors++; $display("FAIL midreset_next: got %h/%b/%b expected 7e/1/0", h_rx_byte, h_rx_rdy, h_framing_err); end
    checks++; if ({strobes - s0, strobe_byte} !== {32'd1, 8'h7E}) begin errors++; $display("FAIL midreset_fifo_next: got %0d/%h expected 1/7e", strobes - s0, strobe_byte); end
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1; bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    read_rx_byte = 1'b0; fifo_full = 1'b0;
    @(negedge clk);
    test_reset();
    test_8n1();
    test_parity7();
    test_framing_break();
    test_glitch_overflow();
    test_fifo();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_async.md
# uart_rx_async

Asynchronous UART receiver for the fabric UART core: the receive-side counterpart of the core's transmit engine. It recovers 7- or 8-bit characters with optional odd/even parity from the serial `rx` line, using a 16x oversampling enable (`baud_clock`). Each character is delivered either to a single holding register with a ready flag (no FIFO) or as a one-cycle write strobe to the receive FIFO. Parity, framing and overflow status are reported alongside the data.

## Interface
Parameters:
- `RX_FIFO`, 0, selects the delivery mode: 0 = holding register with `rx_rdy`; 1 = write strobe to an external RX FIFO.

Ports:
- One clock; reset is synchronous and active-high.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `baud_clock` in 1: one-`clk` enable pulse at 16x the baud rate.
- `rx` in 1: asynchronous serial input; idles high.
- `bit8` in 1: 1 = 8 data bits; 0 = 7 data bits.
- `parity_en` in 1: 1 = a parity bit follows the data bits.
- `odd_n_even` in 1: 1 = odd parity; 0 = even parity.
- `read_rx_byte` in 1: one-cycle host read strobe. Clears `rx_rdy` and `overflow`.
- `fifo_full` in 1: RX FIFO full. Used only when `RX_FIFO=1`.
- `rx_byte` out 8: received character.
- `rx_rdy` out 1: character available. Used only when `RX_FIFO=0`; tied 0 when `RX_FIFO=1`.
- `parity_err` out 1: parity mismatch on the last delivered character.
- `framing_err` out 1: stop bit sampled low on the last delivered character.
- `overflow` out 1: sticky flag; a character was lost.
- `fifo_write_rx` out 1: active-low one-cycle FIFO write strobe.

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer to give `rx_s`. Both flops reset to 1.
- **Gating.** All state, counter and sampling activity advances only on `clk` edges where `baud_clock=1`.
- **State machine.** States are `rx_idle`, `rx_start`, `rx_data`, `rx_parity` and `rx_stop`.
- **Sample counter.** 4-bit `samp_cnt`. It is cleared on entering `rx_start` and increments on each tick in the non-idle states, wrapping from 15 to 0.
- **Bit value.** Each bit is the majority of `rx_s` captured at `samp_cnt` = 6, 7 and 8.
- **`rx_idle`.** A falling edge of `rx_s` between consecutive ticks (previous 1, current 0) moves the FSM to `rx_start`. A line held low therefore never re-triggers reception.
- **`rx_start`.** The voted value is evaluated at count 8.
  - If it is 1, this is a false start: return to `rx_idle`.
  - Otherwise, on the count 15→0 wrap, go to `rx_data`.
- **`rx_data`.**
  - The voted bit shifts in LSB first and is XORed into the running parity.
  - The 3-bit `bit_cnt` advances on each wrap.
  - After bit 7 (`bit8=1`) or bit 6 (`bit8=0`), go to `rx_parity` if `parity_en=1`, else to `rx_stop`.
  - In 7-bit mode, `rx_byte[7]` is 0.
- **`rx_parity`.** The received bit is compared against `odd_n_even ^ xor(data)`; a mismatch flags a parity error. On the wrap, go to `rx_stop`.
- **`rx_stop`.** The stop bit is evaluated at count 8, not at the wrap, so the receiver resynchronizes early for back-to-back characters. It then delivers the character and returns to `rx_idle` in the same cycle. Delivery by mode:
  - **`RX_FIFO=0`, `rx_rdy=0` (or `read_rx_byte=1` in the same cycle):** load `rx_byte`, `parity_err` and `framing_err`, then set `rx_rdy`.
  - **`RX_FIFO=0`, `rx_rdy=1` and no read:** the new character is discarded. `rx_byte` and the error flags keep their old values and `overflow` is set.
  - **`RX_FIFO=1`, `fifo_full=0`:** load `rx_byte` and the flags, and drive `fifo_write_rx=0` for exactly one `clk` cycle.
  - **`RX_FIFO=1`, `fifo_full=1`:** no strobe, nothing is loaded, and `overflow` is set.
- **Framing errors.** A character with a low stop bit is still delivered, with `framing_err=1`.
- **Host read.** `read_rx_byte` clears `rx_rdy` and `overflow`.
  - Read coinciding with delivery: delivery wins. `rx_rdy` stays 1 and `overflow` is not set.
  - Read coinciding with an overflow event: `overflow` ends at 1.
- **Configuration inputs.** `bit8`, `parity_en` and `odd_n_even` must be static during reception. Changing them mid-character gives an undefined result for that character only.

## Timing
- **Reset.** `rx_byte=0x00`, `rx_rdy=0`, `parity_err=0`, `framing_err=0`, `overflow=0`, `fifo_write_rx=1`. The FSM resets to `rx_idle` with both counters at 0.
- **Reset mid-character.** The partial character is discarded. Reception resumes only on the next falling edge seen after reset.
- **Delivery latency.** Outputs update at the `clk` edge after the stop-bit count-8 tick is registered. Measured from the stop bit's midpoint, this is at most 1 `clk` plus the 2-flop synchronizer delay.
- **FIFO strobe.** `fifo_write_rx` is low for exactly one `clk` cycle, and `rx_byte` is valid during that cycle.
- **Start-edge jitter.** Detection jitter is at most one `baud_clock` period (1/16 bit).

## Test plan
- **8N1 reception.** `RX_FIFO=0`, 8N1, send 0xA5 → `rx_byte=0xA5`, `rx_rdy=1`, all error flags 0. Pulse `read_rx_byte` → `rx_rdy=0`.
- **7-bit parity.** 7E1 sending 0x53 with a correct parity bit → `rx_byte=0x53`, `parity_err=0`. Repeat with the parity bit inverted → `parity_err=1`. 7O1 sending 0x00 with parity bit 1 → no error.
- **Framing error and break.**
  - Send 0x3C with the stop bit low → `rx_byte=0x3C`, `framing_err=1`.
  - Then hold `rx` low for 40 bit times → no further deliveries.
  - Then release high and send 0x01 → delivered with `framing_err=0`.
- **Glitch and overflow.** Apply a 4-tick low glitch → no delivery. Send 0x11 then 0x22 back to back with no read → `rx_byte=0x11`, `overflow=1`. Pulse `read_rx_byte` → both flags clear.
- **FIFO mode.** `RX_FIFO=1`:
  - Send 0x80 with `fifo_full=0` → exactly one low cycle on `fifo_write_rx` with `rx_byte=0x80`.
  - Send with `fifo_full=1` → no strobe, `overflow=1`.
- **Reset during reception.** Assert `reset` during data bit 3 → all outputs return to reset values. The next full character 0x7E is received correctly.
